player_position_tracker: RTL and testbench



---
 rtl/pos_pkg.sv | 44 ++++
 rtl/vsync_tick.sv | 28 ++
 rtl/player_position_tracker.sv | 179 +++++++++++++++++
 tb/tb_player_position_tracker.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_pkg.sv
// Shared types and helpers for the player position tracker.
package pos_pkg;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUERY,
        ST_STEP,
        ST_COMMIT,
        ST_BUMP
    } trk_state_t;

    localparam logic [3:0] GAME_STATE_MAIN = 4'd3;

    typedef struct packed {
        logic       off_map;
        logic [5:0] tx;
        logic [5:0] ty;
    } nbr_t;

    // Neighbour tile one step along dir; off_map set (and tile unchanged) at the map edge.
    function automatic nbr_t neighbour(input logic [5:0] tx, input logic [5:0] ty,
                                       input dir_t dir,
                                       input logic [5:0] max_x, input logic [5:0] max_y);
        nbr_t n;
        n.off_map = 1'b0;
        n.tx      = tx;
        n.ty      = ty;
        case (dir)
            DOWN:  if (ty == max_y) n.off_map = 1'b1; else n.ty = ty + 6'd1;
            UP:    if (ty == 6'd0)  n.off_map = 1'b1; else n.ty = ty - 6'd1;
            LEFT:  if (tx == 6'd0)  n.off_map = 1'b1; else n.tx = tx - 6'd1;
            RIGHT: if (tx == max_x) n.off_map = 1'b1; else n.tx = tx + 6'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vsync_tick.sv
// Brings VGA_VS into the Clk domain and turns its rising edge into a one-Clk frame_tick.
module vsync_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic VGA_VS,
    output logic frame_tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= VGA_VS;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign frame_tick = sync2 & ~sync3;

endmodule

// File: rtl/player_position_tracker.sv
// Player world position: walkability query, pixel-by-pixel stepping, tile commit.
//
// state     | meaning
// ST_IDLE   | waiting for a frame tick with a walk request in the main game state
// ST_QUERY  | blk_req high, waiting for the walkability answer or timeout
// ST_STEP   | walking; offset moves one pixel every FRAMES_PER_PX frames
// ST_COMMIT | tile takes the target value, offset cleared
// ST_BUMP   | walk refused, one-Clk bump pulse
module player_position_tracker
    import pos_pkg::*;
#(
    parameter int MAP_W         = 64,
    parameter int MAP_H         = 64,
    parameter int TILE_PX       = 16,
    parameter int FRAMES_PER_PX = 2,
    parameter int START_X       = 10,
    parameter int START_Y       = 12,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        VGA_VS,
    input  logic [3:0]  state_num,
    input  logic        charIsMoving,
    input  logic [1:0]  direction,
    output logic        blk_req,
    output logic [5:0]  blk_tx,
    output logic [5:0]  blk_ty,
    input  logic        blk_ack,
    input  logic        blk_blocked,
    output logic [5:0]  tileX,
    output logic [5:0]  tileY,
    output logic [10:0] posX,
    output logic [10:0] posY,
    output logic        walking,
    output logic        bump
);

    localparam int TSH   = $clog2(TILE_PX);
    localparam int OFS_W = TSH + 2;
    localparam int DIV_W = (FRAMES_PER_PX > 1) ? $clog2(FRAMES_PER_PX) : 1;
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic signed [OFS_W-1:0] OFS_MAX = OFS_W'(TILE_PX);
    localparam logic signed [OFS_W-1:0] OFS_MIN = -OFS_MAX;

    trk_state_t              state;
    trk_state_t              state_nxt;
    dir_t                    dir_q;
    logic [5:0]              tile_x;
    logic [5:0]              tile_y;
    logic [5:0]              tgt_x;
    logic [5:0]              tgt_y;
    logic signed [OFS_W-1:0] offset;
    logic [DIV_W-1:0]        frame_div;
    logic [ACK_W-1:0]        ack_cnt;
    logic [10:0]             pos_x;
    logic [10:0]             pos_y;
    logic                    frame_tick;
    logic                    in_game;
    logic                    walk_start;
    logic                    ofs_full;
    logic [10:0]             ofs_ext;
    nbr_t                    nbr;

    vsync_tick u_vsync_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .VGA_VS     (VGA_VS),
        .frame_tick (frame_tick)
    );

    assign in_game    = (state_num == GAME_STATE_MAIN);
    assign walk_start = frame_tick & in_game & charIsMoving;
    assign ofs_full   = (offset == OFS_MAX) || (offset == OFS_MIN);
    assign ofs_ext    = {{(11-OFS_W){offset[OFS_W-1]}}, offset};
    assign nbr        = neighbour(tile_x, tile_y, dir_t'(direction),
                                  6'(MAP_W - 1), 6'(MAP_H - 1));

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and strobe decode; strobes come straight from the state so reset clears them at once.
    always_comb begin
        state_nxt = state;
        blk_req   = 1'b0;
        walking   = 1'b0;
        bump      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (walk_start) state_nxt = nbr.off_map ? ST_BUMP : ST_QUERY;
            end
            ST_QUERY: begin
                blk_req = 1'b1;
                if (blk_ack)             state_nxt = blk_blocked ? ST_BUMP : ST_STEP;
                else if (ack_cnt == '0)  state_nxt = ST_BUMP;
            end
            ST_STEP: begin
                walking = 1'b1;
                if (ofs_full) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            ST_BUMP: begin
                bump      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Walk datapath: latch request, count down ack timeout and frame divider, move and commit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dir_q     <= DOWN;
            tile_x    <= 6'(START_X);
            tile_y    <= 6'(START_Y);
            tgt_x     <= 6'(START_X);
            tgt_y     <= 6'(START_Y);
            offset    <= '0;
            frame_div <= '0;
            ack_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (walk_start) begin
                        dir_q     <= dir_t'(direction);
                        tgt_x     <= nbr.tx;
                        tgt_y     <= nbr.ty;
                        ack_cnt   <= ACK_W'(ACK_TIMEOUT - 1);
                        frame_div <= DIV_W'(FRAMES_PER_PX - 1);
                    end
                end
                ST_QUERY: begin
                    if (!blk_ack && ack_cnt != '0) ack_cnt <= ack_cnt - 1'b1;
                end
                ST_STEP: begin
                    // Frozen outside the main game state so a paused walk resumes where it stopped.
                    if (frame_tick && in_game && !ofs_full) begin
                        if (frame_div == '0) begin
                            frame_div <= DIV_W'(FRAMES_PER_PX - 1);
                            if (dir_q == DOWN || dir_q == RIGHT) offset <= offset + OFS_W'(1);
                            else                                 offset <= offset - OFS_W'(1);
                        end else begin
                            frame_div <= frame_div - 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    tile_x <= tgt_x;
                    tile_y <= tgt_y;
                    offset <= '0;
                end
                default: ;
            endcase
        end
    end

    // Registered world pixel position; the offset applies only on the axis being walked.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pos_x <= 11'(START_X * TILE_PX);
            pos_y <= 11'(START_Y * TILE_PX);
        end else begin
            pos_x <= (11'(tile_x) << TSH) + (dir_q[1]  ? ofs_ext : 11'd0);
            pos_y <= (11'(tile_y) << TSH) + (!dir_q[1] ? ofs_ext : 11'd0);
        end
    end

    assign blk_tx = tgt_x;
    assign blk_ty = tgt_y;
    assign tileX  = tile_x;
    assign tileY  = tile_y;
    assign posX   = pos_x;
    assign posY   = pos_y;

endmodule

// File: tb/tb_player_position_tracker.sv
// Scoreboard bench for player_position_tracker: directed walks, refusals, freeze and reset.
module tb_player_position_tracker;

    localparam int K_QUERY  = 0;
    localparam int K_BUMP   = 1;
    localparam int K_COMMIT = 2;

    logic        Clk;
    logic        Reset;
    logic        VGA_VS;
    logic [3:0]  state_num;
    logic        charIsMoving;
    logic [1:0]  direction;
    logic        blk_req;
    logic [5:0]  blk_tx;
    logic [5:0]  blk_ty;
    logic        blk_ack;
    logic        blk_blocked;
    logic [5:0]  tileX;
    logic [5:0]  tileY;
    logic [10:0] posX;
    logic [10:0] posY;
    logic        walking;
    logic        bump;

    typedef struct {
        int kind;
        int a;
        int b;
        int px;
        int py;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   n_query;
    int   cur_x;
    int   cur_y;
    int   ack_delay;
    bit   ack_blk;
    bit   withhold;
    int   resp_d;
    bit   req_q;
    bit   walk_q;
    int   pend;

    player_position_tracker dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .VGA_VS       (VGA_VS),
        .state_num    (state_num),
        .charIsMoving (charIsMoving),
        .direction    (direction),
        .blk_req      (blk_req),
        .blk_tx       (blk_tx),
        .blk_ty       (blk_ty),
        .blk_ack      (blk_ack),
        .blk_blocked  (blk_blocked),
        .tileX        (tileX),
        .tileY        (tileY),
        .posX         (posX),
        .posY         (posY),
        .walking      (walking),
        .bump         (bump)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial VGA_VS = 1'b0;
    always #100 VGA_VS = ~VGA_VS;

    task automatic check_eq(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic pop_expect(input int kind, input int a, input int b,
                              input int px, input int py, input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected event at x=%0d y=%0d, expected none", nm, a, b);
        end else begin
            e = sb.pop_front();
            check_eq({nm, "_kind"}, kind, e.kind);
            check_eq({nm, "_x"}, a, e.a);
            check_eq({nm, "_y"}, b, e.b);
            if (kind != K_QUERY) begin
                check_eq({nm, "_px"}, px, e.px);
                check_eq({nm, "_py"}, py, e.py);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a query, bump or completed walk.
    initial begin
        req_q  = 1'b0;
        walk_q = 1'b0;
        pend   = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                req_q  = 1'b0;
                walk_q = 1'b0;
                pend   = 0;
            end else begin
                if (blk_req && !req_q) begin
                    n_query++;
                    pop_expect(K_QUERY, blk_tx, blk_ty, 0, 0, "query");
                end
                if (bump) pop_expect(K_BUMP, tileX, tileY, posX, posY, "bump");
                if (!walking && walk_q) pend = 3;
                else if (pend > 0) begin
                    pend--;
                    if (pend == 0) pop_expect(K_COMMIT, tileX, tileY, posX, posY, "commit");
                end
                req_q  = blk_req;
                walk_q = walking;
            end
        end
    end

    // Walkability map responder.
    initial begin
        blk_ack     = 1'b0;
        blk_blocked = 1'b0;
        forever begin
            @(negedge Clk);
            if (blk_req && !Reset) begin
                resp_d = withhold ? 20 : ack_delay;
                repeat (resp_d - 1) @(negedge Clk);
                blk_ack     = 1'b1;
                blk_blocked = ack_blk;
                @(negedge Clk);
                blk_ack     = 1'b0;
                blk_blocked = 1'b0;
            end
        end
    end

    task automatic walk(input int d, input bit px_chk);
        int nx, ny, cnt, lastp, p, frames, changes;
        logic vprev;
        nx = cur_x;
        ny = cur_y;
        case (d)
            0: ny++;
            1: ny--;
            2: nx--;
            default: nx++;
        endcase
        sb.push_back('{K_QUERY, nx, ny, 0, 0});
        sb.push_back('{K_COMMIT, nx, ny, nx * 16, ny * 16});
        direction    = 2'(d);
        charIsMoving = 1'b1;
        cnt = 0;
        while (!walking && cnt < 200) begin
            @(negedge Clk);
            cnt++;
        end
        check_eq("walk_start", walking, 1);
        charIsMoving = 1'b0;
        lastp   = (d >= 2) ? int'(posX) : int'(posY);
        frames  = 0;
        changes = 0;
        vprev   = VGA_VS;
        cnt     = 0;
        while (walking && cnt < 2000) begin
            @(negedge Clk);
            cnt++;
            if (VGA_VS && !vprev) frames++;
            vprev = VGA_VS;
            if (px_chk) begin
                p = (d >= 2) ? int'(posX) : int'(posY);
                if (p != lastp) begin
                    changes++;
                    check_eq("px_delta", p - lastp, (d == 0 || d == 3) ? 1 : -1);
                    check_eq("px_frames", frames, 2);
                    frames = 0;
                    lastp  = p;
                end
            end
        end
        check_eq("walk_end", walking, 0);
        if (px_chk) check_eq("px_changes", changes, 16);
        repeat (5) @(negedge Clk);
        cur_x = nx;
        cur_y = ny;
    endtask

    task automatic wait_bump(output bit seen, output bit walked, output bit req);
        int cnt;
        seen   = 1'b0;
        walked = 1'b0;
        req    = 1'b0;
        cnt    = 0;
        while (!seen && cnt < 300) begin
            @(negedge Clk);
            cnt++;
            if (walking) walked = 1'b1;
            if (blk_req) req = 1'b1;
            if (bump) seen = 1'b1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_tileX"}, tileX, 10);
        check_eq({tag, "_tileY"}, tileY, 12);
        check_eq({tag, "_posX"}, posX, 160);
        check_eq({tag, "_posY"}, posY, 192);
        check_eq({tag, "_blk_req"}, blk_req, 0);
        check_eq({tag, "_walking"}, walking, 0);
        check_eq({tag, "_bump"}, bump, 0);
    endtask

    initial begin
        #500_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bit seen, walked, req;
        int cnt, q0;
        n_checks     = 0;
        n_fail       = 0;
        n_query      = 0;
        cur_x        = 10;
        cur_y        = 12;
        ack_delay    = 2;
        ack_blk      = 1'b0;
        withhold     = 1'b0;
        Reset        = 1'b1;
        state_num    = 4'd0;
        charIsMoving = 1'b0;
        direction    = 2'd0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(posedge VGA_VS);
        repeat (5) @(negedge Clk);
        check_reset_vals("init");
        state_num = 4'd3;

        // Blocked target: one bump, no walk.
        ack_blk = 1'b1;
        sb.push_back('{K_QUERY, 11, 12, 0, 0});
        sb.push_back('{K_BUMP, 10, 12, 160, 192});
        direction    = 2'd3;
        charIsMoving = 1'b1;
        wait_bump(seen, walked, req);
        charIsMoving = 1'b0;
        check_eq("blocked_bump_seen", seen, 1);
        check_eq("blocked_walked", walked, 0);
        ack_blk = 1'b0;
        repeat (5) @(negedge Clk);
        check_eq("blocked_tileX", tileX, 10);

        // Clear walk right with per-pixel cadence check.
        walk(3, 1'b1);

        // Ack withheld: timeout bump after 15 cycles, late ack ignored.
        withhold = 1'b1;
        sb.push_back('{K_QUERY, 12, 12, 0, 0});
        sb.push_back('{K_BUMP, 11, 12, 176, 192});
        direction    = 2'd3;
        charIsMoving = 1'b1;
        cnt = 0;
        while (!blk_req && cnt < 200) begin
            @(negedge Clk);
            cnt++;
        end
        cnt = 0;
        while (!bump && cnt < 40) begin
            @(negedge Clk);
            cnt++;
        end
        charIsMoving = 1'b0;
        check_eq("timeout_cycles", cnt, 15);
        repeat (30) @(negedge Clk);
        check_eq("late_ack_tileX", tileX, 11);
        check_eq("late_ack_posX", posX, 176);
        check_eq("late_ack_walking", walking, 0);
        check_eq("late_ack_blk_req", blk_req, 0);
        withhold = 1'b0;

        // Walk left to column 0, then try to leave the map.
        for (int i = 0; i < 11; i++) walk(2, 1'b0);
        check_eq("edge_tileX", tileX, 0);
        sb.push_back('{K_BUMP, 0, 12, 0, 192});
        q0           = n_query;
        direction    = 2'd2;
        charIsMoving = 1'b1;
        wait_bump(seen, walked, req);
        charIsMoving = 1'b0;
        repeat (5) @(negedge Clk);
        check_eq("edge_bump_seen", seen, 1);
        check_eq("edge_req_seen", req, 0);
        check_eq("edge_query_count", n_query, q0);

        // Walk down, pause outside the game state at posY=200, then resume.
        sb.push_back('{K_QUERY, 0, 13, 0, 0});
        sb.push_back('{K_COMMIT, 0, 13, 0, 208});
        direction    = 2'd0;
        charIsMoving = 1'b1;
        cnt = 0;
        while (!walking && cnt < 200) begin
            @(negedge Clk);
            cnt++;
        end
        charIsMoving = 1'b0;
        cnt = 0;
        while (posY != 11'd200 && cnt < 1000) begin
            @(negedge Clk);
            cnt++;
        end
        check_eq("freeze_reach", posY, 200);
        state_num = 4'd0;
        direction = 2'd3;
        repeat (10) @(posedge VGA_VS);
        repeat (4) @(negedge Clk);
        check_eq("freeze_posY", posY, 200);
        check_eq("freeze_posX", posX, 0);
        check_eq("freeze_walking", walking, 1);
        state_num = 4'd3;
        cnt = 0;
        while (walking && cnt < 1000) begin
            @(negedge Clk);
            cnt++;
        end
        check_eq("resume_done", walking, 0);
        repeat (6) @(negedge Clk);
        check_eq("resume_tileY", tileY, 13);
        check_eq("resume_tileX", tileX, 0);

        // Asynchronous reset in the middle of a step.
        sb.push_back('{K_QUERY, 0, 14, 0, 0});
        direction    = 2'd0;
        charIsMoving = 1'b1;
        cnt = 0;
        while (!walking && cnt < 200) begin
            @(negedge Clk);
            cnt++;
        end
        charIsMoving = 1'b0;
        repeat (6) @(posedge VGA_VS);
        @(negedge Clk);
        check_eq("pre_reset_tileY", tileY, 13);
        #2 Reset = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        check_eq("post_reset_tileY", tileY, 12);
        check_eq("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
